// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// state encoding and a constant-foldable clog2 for sizing the cycle counter.
package vedic_pkg;

    // Controller state encoding; the fourth code is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2, usable in parameter context.
    function automatic int clog2(input int value);
        int res;
        int x;
        res = 0;
        x   = value - 1;
        while (x > 0) begin
            res = res + 1;
            x   = x >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/vedic_seq_mult_ctrl.sv
// Sequential shift-add multiplier controller. Feeds an external N-bit adder
// once per cycle and folds its Sum/Cout back into a 2N-bit product register,
// so exact and approximate adders can be swapped without touching this block.
module vedic_seq_mult_ctrl
    import vedic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    output logic             add_cin,
    input  logic [N-1:0]     add_sum,
    input  logic             add_cout
);

    localparam int CW = clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [2*N-1:0] p_q, p_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   hi;
    logic [N-1:0]   lo;
    logic           st_idle, st_run, st_done;

    assign hi      = p_q[2*N-1:N];
    assign lo      = p_q[N-1:0];
    assign st_idle = (state_q == ST_IDLE);
    assign st_run  = (state_q == ST_RUN);
    assign st_done = (state_q == ST_DONE);

    // Handshake and adder drive; adder inputs are held at zero outside RUN
    // so the attached adder only toggles while a product is being built.
    always_comb begin
        in_ready  = st_idle;
        out_valid = st_done;
        out_p     = st_done ? p_q : '0;
        add_a     = st_run ? hi : '0;
        add_b     = (st_run && lo[0]) ? a_q : '0;
        add_cin   = 1'b0;
    end

    // Next-state: capture on accept, shift-add for N cycles, hold until taken.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    p_d     = {{N{1'b0}}, in_b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Adder result becomes the new high half; multiplier bits
                // shift out of the low half as product bits shift in.
                p_d   = {add_cout, add_sum, lo[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A coincident in_valid is deliberately not taken here; the
                // source holds it and it is accepted in the following IDLE.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers, asynchronously cleared; a reset mid-operation
    // discards the partial product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Randomized bench for vedic_seq_mult_ctrl with an exact or approximate
// adder model attached to the add_* ports and a shift-add reference model.
module tb_vedic_seq_mult_ctrl;

    localparam int N = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;
    logic [N-1:0]     add_a;
    logic [N-1:0]     add_b;
    logic             add_cin;
    logic [N-1:0]     add_sum;
    logic             add_cout;

    int total;
    int bad;
    bit approx_mode;
    bit saw_cout;

    vedic_seq_mult_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p    (out_p),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden adders: exact sum, or a lower-part-OR approximation where the
    // two low bits are ORed and only an a1&b1 carry enters the upper part.
    function automatic int adder(input int x, input int y, input int c, input bit apx);
        int lo2;
        int up;
        if (!apx) return x + y + c;
        lo2 = (x | y) & 3;
        up  = (x >> 2) + (y >> 2) + ((x >> 1) & (y >> 1) & 1);
        return (up << 2) | lo2;
    endfunction

    always_comb begin
        int r;
        r        = adder(int'(add_a), int'(add_b), int'(add_cin), approx_mode);
        add_sum  = r[N-1:0];
        add_cout = r[N];
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full operation: accept, N RUN cycles checked against the model,
    // optional stall in DONE, optional output handshake.
    task automatic run_op(input int a, input int b, input int stall, input bit release_out);
        int p;
        int hi;
        int lo;
        int bb;
        int r;
        int guard;
        in_a     = N'(a);
        in_b     = N'(b);
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("accept_wait", longint'(guard < 50), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        p = b;
        for (int i = 0; i < N; i++) begin
            hi = p >> N;
            lo = p & ((1 << N) - 1);
            bb = (lo & 1) ? a : 0;
            chk("run_in_ready", in_ready, 0);
            chk("run_out_valid", out_valid, 0);
            chk("run_add_a", add_a, hi);
            chk("run_add_b", add_b, bb);
            chk("run_add_cin", add_cin, 0);
            if (add_cout) saw_cout = 1'b1;
            r = adder(hi, bb, 0, approx_mode);
            p = (r << (N - 1)) | (lo >> 1);
            @(posedge clk); #1;
        end
        chk("done_out_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        chk("done_out_p", out_p, p);
        if (!approx_mode) chk("done_out_p_arith", out_p, a * b);
        for (int s = 0; s < stall; s++) begin
            in_valid = (s % 2) == 0;
            in_a     = N'($urandom);
            in_b     = N'($urandom);
            @(posedge clk); #1;
            chk("stall_out_p", out_p, p);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("rel_out_valid", out_valid, 0);
            chk("rel_in_ready", in_ready, 1);
            chk("rel_out_p", out_p, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        approx_mode = 1'b0;
        saw_cout    = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_a        = '0;
        in_b        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(13, 11, 0, 1);
        saw_cout = 1'b0;
        run_op(255, 255, 0, 1);
        chk("cout_seen", saw_cout, 1);
        run_op(200, 0, 0, 1);

        // Stall with ignored in_valid, then release with a new operand
        // already presented: only the output handshake completes.
        run_op(7, 9, 5, 0);
        in_a      = 8'd3;
        in_b      = 8'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("dual_out_valid", out_valid, 0);
        chk("dual_in_ready", in_ready, 1);
        run_op(3, 5, 0, 1);

        // Reset mid-RUN
        in_a     = 8'd100;
        in_b     = 8'd100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_p", out_p, 0);
        chk("arst_add_a", add_a, 0);
        chk("arst_add_b", add_b, 0);
        chk("arst_add_cin", add_cin, 0);
        repeat (10) begin
            @(posedge clk); #1;
            chk("arst_hold_out_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        run_op(2, 3, 0, 1);

        // Random exact operands
        for (int k = 0; k < 12; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2)), 1);
        end

        // Approximate adder swapped in
        approx_mode = 1'b1;
        run_op(37, 91, 0, 1);
        for (int k = 0; k < 4; k++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1);
        end
        approx_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
